// File: rtl/serial_gp_adder_pkg.sv
// Shared constants for the bit-serial generate/propagate adder.
// State encoding and the default operand width.
package serial_gp_adder_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_gp_adder_gp.sv
// Single generate/propagate cell: g = a & b, p = a ^ b.
// Purely combinational; the carry and sum terms are built around it by the caller.
module gp_cell (
  input  logic ai,
  input  logic bi,
  output logic gi,
  output logic pi
);

  assign gi = ai & bi;
  assign pi = ai ^ bi;

endmodule

// File: rtl/serial_gp_adder.sv
// Bit-serial adder: one operand bit pair per clock, LSB first, through a G/P cell.
// start/busy/done handshake; {cout,sum} = a + b + cin, ovf is two's-complement overflow.
module serial_gp_adder
  import serial_gp_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output state_t           dbg_state
);

  // Handshake: start is sampled only while idle (busy low); once accepted,
  // done pulses high for exactly one cycle and sum/cout/ovf are valid from
  // that cycle until the next accepted start.

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic [CNT_W-1:0] r_cnt;

  logic w_g;
  logic w_p;
  logic w_s;
  logic w_c;

  gp_cell u_gp (
    .ai (r_a[0]),
    .bi (r_b[0]),
    .gi (w_g),
    .pi (w_p)
  );

  assign w_s = w_p ^ r_carry;
  assign w_c = w_g | (w_p & r_carry);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_cnt   <= '0;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          // Sum bits enter at the MSB so the first bit ends up at bit 0.
          r_sum   <= {w_s, r_sum[WIDTH-1:1]};
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_carry <= w_c;
          if (r_cnt == LAST) begin
            r_cout  <= w_c;
            r_ovf   <= r_carry ^ w_c;
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_DONE);
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_serial_gp_adder.sv
// Directed bench for serial_gp_adder: driver pushes hand-computed results into a
// queue, a done-triggered monitor pops and compares result fields and latency.
module tb_serial_gp_adder;
  import serial_gp_adder_pkg::*;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  state_t       dbg_state;

  serial_gp_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;

  // scoreboard: {cout, ovf, sum} and the accept-edge cycle of each operation
  logic [W+1:0] exp_q[$];
  int           acc_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    if (!rst && done) begin
      logic [W+1:0] e;
      int           acc;
      done_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e   = exp_q.pop_front();
        acc = acc_q.pop_front();
        chk("sum",     {24'd0, sum}, {24'd0, e[W-1:0]});
        chk("cout",    {31'd0, cout}, {31'd0, e[W+1]});
        chk("ovf",     {31'd0, ovf}, {31'd0, e[W]});
        chk("latency", cyc - acc, W);
      end
    end
  end

  // driver tasks
  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                       input logic [W-1:0] es, input logic ec, input logic eo);
    wait_idle();
    a = ia; b = ib; cin = ic; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    exp_q.push_back({ec, eo, es});
    acc_q.push_back(cyc);
  endtask

  task automatic wait_empty();
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("done_timeout", 32'd1, 32'd0);
      exp_q.delete();
      acc_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int d0;
    int low_cnt;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sum",   {24'd0, sum}, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_done",  {31'd0, done}, 32'd0);
    chk("rst_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    @(negedge clk);
    rst = 1'b0;

    // 1: reset mid-RUN, then the same add completes
    do_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_sum",   {24'd0, sum}, 32'd0);
    chk("mid_rst_cout",  {31'd0, cout}, 32'd0);
    chk("mid_rst_ovf",   {31'd0, ovf}, 32'd0);
    chk("mid_rst_busy",  {31'd0, busy}, 32'd0);
    chk("mid_rst_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    exp_q.delete();
    acc_q.delete();
    @(negedge clk);
    rst = 1'b0;
    do_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);
    wait_empty();

    // 2: carry ripple and wrap
    do_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    wait_empty();

    // 3: signed overflow, positive and negative
    do_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    wait_empty();
    do_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    wait_empty();

    // 4: all-propagate chain with carry-in
    do_op(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0);
    wait_empty();

    // 5: start pulse during RUN must be ignored
    d0 = done_cnt;
    do_op(8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0);
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_empty();
    repeat (12) @(negedge clk);
    chk("busy_start_dones", done_cnt - d0, 1);
    chk("busy_start_idle",  {31'd0, busy}, 32'd0);

    // 6: back-to-back with start held high
    wait_idle();
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({1'b0, 1'b0, 8'h30});
      acc_q.push_back(cyc + 1 + 10 * i);
    end
    low_cnt = 0;
    for (int i = 0; i < 21; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (!busy) low_cnt++;
    end
    start = 1'b0;
    chk("b2b_busy_low_cycles", low_cnt, 2);
    wait_empty();
    repeat (12) @(negedge clk);
    chk("b2b_no_extra", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
